uart_rx_oversampled: RTL and testbench
======================================

UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 Parameter: DATA_BITS, 8, data bits per frame (5..8).
REQ-002 Parameter: OVERSAMPLE, 16, baud ticks per bit period.
REQ-003 Port: clk  input  1  system clock.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: baud_pwm  input  1  level from baud clock divider; one rising edge per oversample period (652 clk at default divider settings).
REQ-006 Port: rx  input  1  asynchronous serial line, idle high.
REQ-007 Port: rx_data  output  DATA_BITS  last received byte, LSB first on the line.
REQ-008 Port: rx_valid  output  1  byte available; held until acknowledged.
REQ-009 Port: rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-010 Port: frame_err  output  1  one-clk pulse, stop bit sampled low.
REQ-011 Port: overrun  output  1  sticky, byte completed while rx_valid=1.
REQ-012 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL synchronize rx with two flops reset to 1; all decisions use the synchronized value.
REQ-014 The block SHALL derive tick as a one-clk pulse on each baud_pwm rising edge (registered previous value, reset 0); all counters advance on tick only.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP; reset to IDLE.
REQ-016 IDLE: on tick with rx_s=0 -> START, tick counter cleared to 0.
REQ-017 START: at sample point (REQ-027) rx_s=1 -> IDLE (glitch rejected, no output); rx_s=0 -> continue; at count OVERSAMPLE-1 -> DATA, counter 0, bit index 0.
REQ-018 DATA: sample each bit at the sample point, shift into rx_data shift register LSB first; at count OVERSAMPLE-1 advance bit index; after bit DATA_BITS-1 -> STOP.
REQ-019 STOP: at sample point, rx_s=1 -> load rx_data, set rx_valid; rx_s=0 -> pulse frame_err, rx_data and rx_valid unchanged; both cases -> IDLE in the same clk (early resync).
REQ-020 rx_valid SHALL assert on the clk after the stop-bit sample tick and remain high until rx_ack=1 sampled.
REQ-021 Load with rx_valid=1 and rx_ack=0 SHALL overwrite rx_data and set overrun; overrun clears only on rx_ack=1 or reset.
REQ-022 Load and rx_ack in the same clk: load wins, rx_valid stays 1, overrun not set.
REQ-023 rx_ack with rx_valid=0 SHALL have no effect.
REQ-024 Tick counter width SHALL be ceil(log2(OVERSAMPLE)); counter wraps to 0 at OVERSAMPLE-1.

Reset
REQ-025 On reset: state IDLE, counters 0, rx_data 0, rx_valid 0, frame_err 0, overrun 0, busy 0, sync flops 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no rx_valid or frame_err; reception restarts at the next falling edge after release.

Configuration
REQ-027 Macro UART_RX_MAJORITY_EN defined: each bit value SHALL be the 2-of-3 majority of rx_s at counts OVERSAMPLE/2-2, -1, 0, decided at count OVERSAMPLE/2 (6,7,8 -> decision at 8). Undefined: single sample at count OVERSAMPLE/2-1 (7).
REQ-028 Majority mode SHALL apply identically to start, data and stop bits; outputs and latency otherwise identical apart from the one-tick later decision.

Verification
REQ-029 Frame 0xA5, 8N1, bit period 16 ticks -> rx_data=0xA5, rx_valid=1 held until rx_ack, frame_err=0, overrun=0.
REQ-030 rx low for 4 ticks then high -> state returns to IDLE, busy falls, no rx_valid, no frame_err.
REQ-031 Frame 0x3C with stop bit 0 -> frame_err single-clk pulse, rx_valid stays 0, rx_data unchanged.
REQ-032 Frames 0x11 then 0x22 without rx_ack -> rx_data=0x22, rx_valid=1, overrun=1; rx_ack -> rx_valid=0, overrun=0.
REQ-033 Reset asserted at data bit 4 of 0xFF, frame continues -> no output; next frame 0x5A received correctly.
REQ-034 UART_RX_MAJORITY_EN defined, 0x00 frame with one-tick high glitch at count 7 of bit 3 -> rx_data=0x00; macro undefined -> rx_data=0x08.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampling UART receiver (8N1 by default).
// The line is double-flopped into the clk domain. Each rising edge of baud_pwm
// becomes a single-clk tick, and all bit timing is counted in those ticks.
// The bit value is taken at the middle of each bit period. The stop bit is
// sampled, and the receiver then returns to IDLE in the same clk, so it can
// resynchronise early on the next start bit.
// Build option: define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote
// over three consecutive ticks around mid-bit. This gives one tick more
// latency. Without the macro, one sample is taken at mid-bit.
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_pwm,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef UART_RX_MAJORITY_EN
    // Votes are taken at the two ticks before the decision tick and at the decision tick itself.
    localparam logic [CNT_W-1:0] CNT_VOTE_A = CNT_W'(OVERSAMPLE / 2 - 2);
    localparam logic [CNT_W-1:0] CNT_VOTE_B = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(OVERSAMPLE / 2);
`else
    localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(OVERSAMPLE / 2 - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;

    logic rx_meta_p0;
    logic rx_s;
    logic baud_prev;
    logic tick;
    logic decide;
    logic bit_val;
    logic load;
    logic stop_bad;

`ifdef UART_RX_MAJORITY_EN
    logic vote_a;
    logic vote_b;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    // Two-flop synchronizer on the asynchronous line, idling high out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_p0 <= 1'b1;
            rx_s       <= 1'b1;
        end else begin
            rx_meta_p0 <= rx;
            rx_s       <= rx_meta_p0;
        end
    end

    // Remember the previous baud_pwm level so that its rising edge becomes a one-clk tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_prev <= 1'b0;
        end else begin
            baud_prev <= baud_pwm;
        end
    end

    assign tick   = baud_pwm & ~baud_prev;
    assign decide = tick && (cnt == CNT_DECIDE);

`ifdef UART_RX_MAJORITY_EN
    // Capture the two early votes; the third vote is the live sample at the decision tick.
    always_ff @(posedge clk) begin
        if (tick && (cnt == CNT_VOTE_A)) begin
            vote_a <= rx_s;
        end
        if (tick && (cnt == CNT_VOTE_B)) begin
            vote_b <= rx_s;
        end
    end

    assign bit_val = majority3(vote_a, vote_b, rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign load     = decide && (state == STOP) && bit_val;
    assign stop_bad = decide && (state == STOP) && !bit_val;

    // Frame sequencing: start detect, start-bit confirm, data bits, stop bit.
    // busy tracks the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            busy    <= 1'b0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (decide && bit_val) begin
                        // Line went back high by mid start bit: treat it as a glitch.
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= DATA;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (decide) begin
                        // Return to IDLE at the stop sample so that the next start edge is caught early.
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Shift each data bit in at its decision point. The first bit on the line ends up in bit 0.
    always_ff @(posedge clk) begin
        if (decide && (state == DATA)) begin
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
        end
    end

    // Output handshake. A load takes priority over an ack in the same clk.
    // overrun stays set until the consumer acks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            if (load) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                if (rx_ack) begin
                    overrun <= 1'b0;
                end else if (rx_valid) begin
                    overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: bench for uart_rx_oversampled with 8 data bits and 16x oversampling.
// baud_pwm is driven from the bench. Each tick phase is three low clks and then
// one high clk, so the synchronized line value is settled by the time of each
// tick. A reference model tracks the handshake state. Expected bytes are queued
// as each frame is driven and popped when the stop-bit decision is reached.
module tb_uart_rx_oversampled;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_CNT = OVERSAMPLE / 2;
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam int SAMPLE_CNT = OVERSAMPLE / 2 - 1;
    localparam logic [7:0] GLITCH_EXP = 8'h08;
`endif

    logic                 clk;
    logic                 reset;
    logic                 baud_pwm;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    int errors = 0;
    int checks = 0;
    int fe_seen = 0;
    int fe_exp = 0;

    logic       m_valid = 1'b0;
    logic       m_ovr   = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ack;
    } vec_t;

    vec_t vecs[8];

    uart_rx_oversampled #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .baud_pwm (baud_pwm),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_err pulses seen on the opposite edge.
    always @(negedge clk) begin
        if (frame_err) fe_seen++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One baud tick with the line at v; a is driven on rx_ack only for the tick clk.
    task automatic tick(input logic v, input logic a);
        rx       = v;
        rx_ack   = 1'b0;
        baud_pwm = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        baud_pwm = 1'b1;
        rx_ack   = a;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack  = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Drive a complete frame in receiver-tick terms: the detect tick, 16 start ticks, data bits and the stop bit.
    // gbit >= 0 inverts that data bit at count 7 only.
    task automatic send_frame(input logic [7:0] line, input logic [7:0] exp_byte, input logic stop,
                              input int gbit, input logic ack_dec, input string tag);
        logic v;
        logic [7:0] got;
        if (stop) exp_q.push_back(exp_byte);
        tick(1'b0, 1'b0);
        for (int c = 0; c < OVERSAMPLE; c++) tick(1'b0, 1'b0);
        for (int b = 0; b < DATA_BITS; b++) begin
            for (int c = 0; c < OVERSAMPLE; c++) begin
                v = line[b];
                if (b == gbit && c == 7) v = ~v;
                tick(v, 1'b0);
            end
        end
        for (int c = 0; c <= SAMPLE_CNT; c++) tick(stop, (c == SAMPLE_CNT) ? ack_dec : 1'b0);
        if (stop) begin
            if (ack_dec) m_ovr = 1'b0;
            else if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_queue: got empty scoreboard required one entry", tag);
            end else begin
                got = exp_q.pop_front();
                m_data = got;
            end
        end else begin
            fe_exp++;
        end
        check({tag, "_data"}, 32'(rx_data), 32'(m_data));
        check({tag, "_valid"}, 32'(rx_valid), 32'(m_valid));
        check({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
        check({tag, "_frame_err"}, 32'(frame_err), 32'(!stop));
        check({tag, "_busy"}, 32'(busy), 32'h0);
        if (!stop) begin
            @(posedge clk);
            #1;
            check({tag, "_frame_err_width"}, 32'(frame_err), 32'h0);
        end
        for (int c = SAMPLE_CNT + 1; c < OVERSAMPLE; c++) tick(1'b1, 1'b0);
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, stop: 1'b1, ack: 1'b1};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, ack: 1'b0};
        vecs[2] = '{data: 8'h11, stop: 1'b1, ack: 1'b0};
        vecs[3] = '{data: 8'h22, stop: 1'b1, ack: 1'b1};
        vecs[4] = '{data: 8'h00, stop: 1'b1, ack: 1'b1};
        vecs[5] = '{data: 8'hFF, stop: 1'b1, ack: 1'b0};
        vecs[6] = '{data: 8'h81, stop: 1'b1, ack: 1'b0};
        vecs[7] = '{data: 8'h7E, stop: 1'b1, ack: 1'b1};

        reset    = 1'b1;
        rx       = 1'b1;
        baud_pwm = 1'b0;
        rx_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_data", 32'(rx_data), 32'h0);
        check("reset_valid", 32'(rx_valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);

        // Table of frames: data, stop-bit level, and whether to ack afterwards.
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].data, vecs[i].data, vecs[i].stop, -1, 1'b0, $sformatf("vec%0d", i));
            if (vecs[i].ack) begin
                repeat (20) @(posedge clk);
                #1;
                check($sformatf("vec%0d_hold", i), 32'(rx_valid), 32'h1);
                do_ack();
                check($sformatf("vec%0d_ack_valid", i), 32'(rx_valid), 32'h0);
                check($sformatf("vec%0d_ack_overrun", i), 32'(overrun), 32'h0);
            end
            for (int c = 0; c < 3; c++) tick(1'b1, 1'b0);
        end

        // Short low pulse on the line: the start bit is rejected and no output is produced.
        tick(1'b0, 1'b0);
        check("glitch_busy_up", 32'(busy), 32'h1);
        for (int c = 0; c < 3; c++) tick(1'b0, 1'b0);
        for (int c = 0; c < 12; c++) tick(1'b1, 1'b0);
        check("glitch_busy_down", 32'(busy), 32'h0);
        check("glitch_valid", 32'(rx_valid), 32'(m_valid));
        check("glitch_fe_count", 32'(fe_seen), 32'(fe_exp));

        // Ack while nothing is pending has no effect.
        do_ack();
        check("idle_ack_valid", 32'(rx_valid), 32'h0);
        check("idle_ack_data", 32'(rx_data), 32'(m_data));
        check("idle_ack_overrun", 32'(overrun), 32'h0);

        // Load and ack in the same clk: the new byte stays valid and overrun is not set.
        send_frame(8'h6B, 8'h6B, 1'b1, -1, 1'b0, "same_pre");
        send_frame(8'h94, 8'h94, 1'b1, -1, 1'b1, "same_clk");

        // Reset in the middle of data bit 4 of 0xFF; the rest of the frame is ignored.
        tick(1'b0, 1'b0);
        for (int c = 0; c < OVERSAMPLE; c++) tick(1'b0, 1'b0);
        for (int b = 0; b < 4; b++) for (int c = 0; c < OVERSAMPLE; c++) tick(1'b1, 1'b0);
        for (int c = 0; c < 5; c++) tick(1'b1, 1'b0);
        baud_pwm = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_valid", 32'(rx_valid), 32'h0);
        check("midreset_data", 32'(rx_data), 32'h0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_data  = 8'h00;
        for (int c = 0; c < 11 + 3 * OVERSAMPLE + OVERSAMPLE; c++) tick(1'b1, 1'b0);
        check("midreset_after_valid", 32'(rx_valid), 32'h0);
        check("midreset_after_busy", 32'(busy), 32'h0);
        check("midreset_fe_count", 32'(fe_seen), 32'(fe_exp));
        send_frame(8'h5A, 8'h5A, 1'b1, -1, 1'b0, "post_reset");
        do_ack();

        // 0x00 frame with a one-tick high glitch at count 7 of data bit 3.
        send_frame(8'h00, GLITCH_EXP, 1'b1, 3, 1'b0, "bit_glitch");
        do_ack();

        check("frame_err_total", 32'(fe_seen), 32'(fe_exp));
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
